// File: rtl/mu0_control.sv
// ---------------------------------------------------------------------------
// mu0_control
//   Control sequencer for the MU0 16-bit datapath. Runs the two-phase
//   FETCH/EXECUTE cycle, decodes the opcode held in IR[15:12] and drives the
//   datapath mux selects, ALU function, register load enables and memory
//   strobes. Memory accesses stall until MemRdy. The sequencer halts on STP,
//   on an illegal opcode (8-15) or when one access stalls for TIMEOUT cycles.
//
// Ports
//   Clk     in   system clock, rising edge
//   Reset   in   asynchronous, active-high reset
//   F[3:0]  in   opcode (IR[15:12]), meaningful in EXECUTE
//   N, Z    in   ACC negative / zero flags
//   MemRdy  in   memory completes the current access this cycle
//   Xsel    out  address mux: 0 = PC, 1 = IR[11:0]
//   Asel    out  ALU A mux: 0 = ACC, 1 = PC
//   Ysel    out  ALU B mux: 0 = memory Din, 1 = IR[11:0] zero-extended
//   ALUfs   out  00 pass B, 01 A+B, 10 A-B, 11 A+1
//   ACCce, PCce, IRce  out  register load enables
//   ACCoe   out  ACC drives the memory data bus
//   MEMrq   out  memory request
//   RnW     out  1 = read, 0 = write
//   Halted  out  sticky: STP executed
//   Fault   out  sticky: illegal opcode or memory timeout
//
// Handshake: a memory access is presented with MEMrq=1 and held unchanged
// until the cycle in which MemRdy=1; that cycle completes the access, the
// register enables tied to MemRdy fire on it, and the sequencer advances on
// the following clock edge. MemRdy is ignored whenever MEMrq=0.
// ---------------------------------------------------------------------------
module mu0_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       MemRdy,
  output logic       Xsel,
  output logic       Asel,
  output logic       Ysel,
  output logic [1:0] ALUfs,
  output logic       ACCce,
  output logic       PCce,
  output logic       IRce,
  output logic       ACCoe,
  output logic       MEMrq,
  output logic       RnW,
  output logic       Halted,
  output logic       Fault
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  // The timeout fires on the stall cycle that would bring the counter up to
  // TIMEOUT, so exactly TIMEOUT stalled cycles are spent before HALT.
  localparam logic [CNT_W-1:0] STALL_LIMIT =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] stall_cnt;
  logic             halted_q;
  logic             fault_q;
  logic             set_halted;
  logic             set_fault;
  logic             stall;

  // -------------------------------------------------------------------------
  // Decode: outputs and next state from state, F, N, Z, MemRdy
  // -------------------------------------------------------------------------
  always_comb begin
    Xsel       = 1'b0;
    Asel       = 1'b0;
    Ysel       = 1'b0;
    ALUfs      = 2'b00;
    ACCce      = 1'b0;
    PCce       = 1'b0;
    IRce       = 1'b0;
    ACCoe      = 1'b0;
    MEMrq      = 1'b0;
    RnW        = 1'b1;
    Halted     = halted_q;
    Fault      = fault_q;
    state_next = state;
    set_halted = 1'b0;
    set_fault  = 1'b0;
    stall      = 1'b0;

    case (state)
      FETCH: begin
        // PC+1 is computed on the ALU while the instruction is read.
        Asel  = 1'b1;
        ALUfs = 2'b11;
        MEMrq = 1'b1;
        IRce  = MemRdy;
        PCce  = MemRdy;
        if (MemRdy) state_next = EXECUTE;
      end

      EXECUTE: begin
        case (F)
          4'd0: begin // LDA
            Xsel  = 1'b1;
            MEMrq = 1'b1;
            ACCce = MemRdy;
            if (MemRdy) state_next = FETCH;
          end
          4'd1: begin // STA
            Xsel  = 1'b1;
            MEMrq = 1'b1;
            RnW   = 1'b0;
            ACCoe = 1'b1;
            if (MemRdy) state_next = FETCH;
          end
          4'd2, 4'd3: begin // ADD / SUB
            Xsel  = 1'b1;
            ALUfs = (F == 4'd2) ? 2'b01 : 2'b10;
            MEMrq = 1'b1;
            ACCce = MemRdy;
            if (MemRdy) state_next = FETCH;
          end
          4'd4, 4'd5, 4'd6: begin // JMP / JGE / JNE
            // Target comes from IR[11:0] via the B input; only PCce depends
            // on the condition, the datapath setup is the same.
            Ysel = 1'b1;
            case (F)
              4'd4:    PCce = 1'b1;
              4'd5:    PCce = ~N;
              default: PCce = ~Z;
            endcase
            state_next = FETCH;
          end
          4'd7: begin // STP
            state_next = HALT;
            set_halted = 1'b1;
          end
          default: begin // illegal opcode
            state_next = HALT;
            set_fault  = 1'b1;
          end
        endcase
      end

      default: begin // HALT: everything idle, flags hold
      end
    endcase

    stall = MEMrq & ~MemRdy;

    // Memory timeout. All MemRdy-qualified enables are already 0 here since
    // MemRdy=0, so nothing is loaded on the faulting cycle.
    if (TIMEOUT > 0 && stall && stall_cnt == STALL_LIMIT) begin
      state_next = HALT;
      set_fault  = 1'b1;
    end

    // Reset overrides all outputs immediately, independent of the clock.
    if (Reset) begin
      Xsel   = 1'b0;
      Asel   = 1'b0;
      Ysel   = 1'b0;
      ALUfs  = 2'b00;
      ACCce  = 1'b0;
      PCce   = 1'b0;
      IRce   = 1'b0;
      ACCoe  = 1'b0;
      MEMrq  = 1'b0;
      RnW    = 1'b1;
      Halted = 1'b0;
      Fault  = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State, stall counter and sticky halt flags
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= FETCH;
      stall_cnt <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state || MemRdy) begin
        stall_cnt <= '0;
      end else if (stall && stall_cnt != '1) begin
        // Saturate so a disabled timeout cannot wrap the counter.
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (set_halted) halted_q <= 1'b1;
      if (set_fault)  fault_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// ---------------------------------------------------------------------------
// tb_mu0_control
//   Self-checking bench for mu0_control. A driver applies one cycle of
//   stimulus shortly after each rising edge and pushes the control word the
//   reference model predicts for that cycle; a monitor on the falling edge
//   pops and compares against the DUT outputs.
//   The model works at instruction level: a phase (fetch / execute / halted),
//   the number of stalled cycles of the current access, and the sticky flags.
// ---------------------------------------------------------------------------
module tb_mu0_control;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic [3:0] F;
  logic       N, Z, MemRdy;
  logic       Xsel, Asel, Ysel, ACCce, PCce, IRce, ACCoe, MEMrq, RnW;
  logic       Halted, Fault;
  logic [1:0] ALUfs;

  mu0_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .MemRdy(MemRdy),
    .Xsel(Xsel), .Asel(Asel), .Ysel(Ysel), .ALUfs(ALUfs),
    .ACCce(ACCce), .PCce(PCce), .IRce(IRce), .ACCoe(ACCoe),
    .MEMrq(MEMrq), .RnW(RnW), .Halted(Halted), .Fault(Fault)
  );

  // {Xsel,Asel,Ysel,ALUfs,ACCce,PCce,IRce,ACCoe,MEMrq,RnW,Halted,Fault}
  logic [12:0] act;
  assign act = {Xsel, Asel, Ysel, ALUfs, ACCce, PCce, IRce, ACCoe,
                MEMrq, RnW, Halted, Fault};

  // scoreboard
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;
  int          checks = 0;
  int          errors = 0;

  // reference model state
  int m_ph    = 0;   // 0 fetch, 1 execute, 2 halted
  int m_stall = 0;   // stalled cycles of the current access
  bit m_h     = 0;
  bit m_f     = 0;

  function automatic logic [12:0] word(bit xsel, bit asel, bit ysel, int alu,
                                       bit accce, bit pcce, bit irce,
                                       bit accoe, bit memrq, bit rnw,
                                       bit halted, bit fault);
    logic [1:0] a;
    a = 2'(alu);
    return {xsel, asel, ysel, a, accce, pcce, irce, accoe, memrq, rnw,
            halted, fault};
  endfunction

  // driver: one clock cycle of stimulus plus its predicted control word
  task automatic step(input bit rst, input logic [3:0] op, input bit n,
                      input bit z, input bit rdy);
    logic [12:0] w;
    bit          access;
    @(posedge Clk);
    #1;
    Reset = rst; F = op; N = n; Z = z; MemRdy = rdy;
    access = 0;
    if (rst) begin
      w = word(0,0,0,0, 0,0,0,0, 0,1, 0,0);
      m_ph = 0; m_stall = 0; m_h = 0; m_f = 0;
    end else begin
      if (m_ph == 0) begin
        // instruction read, PC incremented as it lands
        w = word(0,1,0,3, 0,rdy,rdy,0, 1,1, 0,0);
        access = 1;
      end else if (m_ph == 1) begin
        if (op == 4'd0)      begin w = word(1,0,0,0, rdy,0,0,0, 1,1, 0,0); access = 1; end
        else if (op == 4'd1) begin w = word(1,0,0,0, 0,0,0,1,   1,0, 0,0); access = 1; end
        else if (op == 4'd2) begin w = word(1,0,0,1, rdy,0,0,0, 1,1, 0,0); access = 1; end
        else if (op == 4'd3) begin w = word(1,0,0,2, rdy,0,0,0, 1,1, 0,0); access = 1; end
        else if (op == 4'd4) w = word(0,0,1,0, 0,1,0,0,  0,1, 0,0);
        else if (op == 4'd5) w = word(0,0,1,0, 0,!n,0,0, 0,1, 0,0);
        else if (op == 4'd6) w = word(0,0,1,0, 0,!z,0,0, 0,1, 0,0);
        else                 w = word(0,0,0,0, 0,0,0,0,  0,1, 0,0);
      end else begin
        w = word(0,0,0,0, 0,0,0,0, 0,1, m_h,m_f);
      end

      // advance the model to the next cycle
      if (access) begin
        if (rdy) begin
          m_ph = (m_ph == 0) ? 1 : 0;
          m_stall = 0;
        end else begin
          m_stall++;
          if (TIMEOUT > 0 && m_stall == TIMEOUT) begin
            m_ph = 2; m_f = 1; m_stall = 0;
          end
        end
      end else if (m_ph == 1) begin
        if (op >= 4'd4 && op <= 4'd6) m_ph = 0;
        else if (op == 4'd7) begin m_ph = 2; m_h = 1; end
        else begin m_ph = 2; m_f = 1; end
      end
    end
    exp_q.push_back(w);
  endtask

  // monitor
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if (act !== mon_exp) begin
        errors++;
        $display("FAIL ctrl_word t=%0t got=%b exp=%b (X A Y ALU ACCce PCce IRce ACCoe MEMrq RnW H F)",
                 $time, act, mon_exp);
      end
    end
  end

  // stimulus
  logic [3:0] cur_op;
  int         drought;
  int         halt_hold;

  initial begin
    Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0; MemRdy = 1'b0;
    step(1, 4'd0, 0, 0, 0);
    step(1, 4'd0, 0, 0, 1);

    // LDA with memory always ready: 2 cycles
    step(0, 4'd0, 0, 0, 1);
    step(0, 4'd0, 0, 0, 1);
    // JMP (MemRdy ignored in execute), JGE with N=1, JNE with Z=0
    step(0, 4'd4, 0, 0, 1);  step(0, 4'd4, 0, 0, 0);
    step(0, 4'd5, 1, 0, 1);  step(0, 4'd5, 1, 0, 1);
    step(0, 4'd6, 0, 0, 1);  step(0, 4'd6, 0, 0, 1);
    step(0, 4'd6, 0, 1, 1);  step(0, 4'd6, 0, 1, 1);
    // STA stalled 3 cycles
    step(0, 4'd1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 4'd1, 0, 0, 0);
    step(0, 4'd1, 0, 0, 1);
    // ADD stalled, then reset mid-stall
    step(0, 4'd2, 0, 0, 1);
    step(0, 4'd2, 0, 0, 0);
    step(0, 4'd2, 0, 0, 0);
    step(1, 4'd2, 0, 0, 0);
    step(0, 4'd3, 0, 0, 0);
    step(0, 4'd3, 0, 0, 1);
    step(0, 4'd3, 0, 0, 1);
    // fetch timeout, then sit in HALT
    step(1, 4'd0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT + 50; i++) step(0, 4'd0, 0, 0, 0);
    // STP
    step(1, 4'd7, 0, 0, 1);
    step(0, 4'd7, 0, 0, 1);
    step(0, 4'd7, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 4'($urandom_range(0, 15)), 0, 0, 1);
    // illegal opcode
    step(1, 4'd9, 0, 0, 1);
    step(0, 4'd9, 0, 0, 1);
    step(0, 4'd9, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 4'($urandom_range(0, 15)), 0, 0, 1);
    // execute-phase timeout on a load
    step(1, 4'd0, 0, 0, 1);
    step(0, 4'd0, 0, 0, 1);
    for (int i = 0; i < TIMEOUT + 3; i++) step(0, 4'd0, 0, 0, 0);

    // randomized traffic
    step(1, 4'd0, 0, 0, 0);
    cur_op = 4'd0; drought = 0; halt_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      bit rst;
      if (m_ph == 0) begin
        if ($urandom_range(0, 9) == 0) cur_op = 4'(8 + $urandom_range(0, 7));
        else cur_op = 4'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 199) == 0) drought = $urandom_range(5, 20);
      if (drought > 0) begin rdy = 0; drought--; end
      else rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      if (m_ph == 2) begin
        halt_hold++;
        if (halt_hold > 4) begin rst = 1; halt_hold = 0; end
      end
      step(rst, cur_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
    end

    @(posedge Clk);
    #10;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
